// File: rtl/demux1x16_seq_dist_if.sv
// Bundle of the serial-in / parallel-out signals of the 1:16 sequential demux.
// The master drives the serial side; the slave is the demux itself.
interface demux1x16_seq_dist_if #(
    parameter int N_OUT = 16,
    parameter int SEL_W = 4
);
    logic             in_valid;
    logic             in_bit;
    logic [SEL_W-1:0] sel;
    logic             mode;
    logic             clr;
    logic [N_OUT-1:0] out;
    logic [N_OUT-1:0] out_strobe;
    logic [N_OUT-1:0] frame_out;
    logic             frame_done;
    logic [SEL_W-1:0] scan_idx;

    modport master (
        output in_valid, in_bit, sel, mode, clr,
        input  out, out_strobe, frame_out, frame_done, scan_idx
    );

    modport slave (
        input  in_valid, in_bit, sel, mode, clr,
        output out, out_strobe, frame_out, frame_done, scan_idx
    );
endinterface

// File: rtl/demux1x16_seq_dist.sv
// Sequential 1-to-16 demultiplexer.
// Addressed mode writes the channel chosen by sel; auto-scan mode fills channels
// 0..N_OUT-1 from an internal counter and commits the full frame atomically when
// the last channel is written. All outputs are registered (1-cycle latency).
module demux1x16_seq_dist #(
    parameter int N_OUT = 16,
    parameter int SEL_W = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    demux1x16_seq_dist_if.slave         bus
);

    logic [N_OUT-1:0] out_q;
    logic [N_OUT-1:0] out_d;
    logic [N_OUT-1:0] strobe_q;
    logic [N_OUT-1:0] strobe_d;
    logic [N_OUT-1:0] frame_q;
    logic [N_OUT-1:0] frame_d;
    logic             done_q;
    logic             done_d;
    logic [SEL_W-1:0] idx_q;
    logic [SEL_W-1:0] idx_d;
    logic [SEL_W-1:0] target_s;
    logic             last_s;

    // One-hot decode of a channel number.
    function automatic logic [N_OUT-1:0] one_hot(input logic [SEL_W-1:0] idx);
        logic [N_OUT-1:0] base;
        base    = {{(N_OUT-1){1'b0}}, 1'b1};
        one_hot = base << idx;
    endfunction

    // Channel to write this cycle and whether it closes an auto-scan frame.
    always_comb begin
        target_s = bus.mode ? idx_q : bus.sel;
        last_s   = (idx_q == SEL_W'(N_OUT - 1));
    end

    // Next-state: clear beats write; addressed mode pins the scan counter at 0.
    always_comb begin
        out_d    = out_q;
        strobe_d = {N_OUT{1'b0}};
        frame_d  = frame_q;
        done_d   = 1'b0;
        idx_d    = bus.mode ? idx_q : {SEL_W{1'b0}};
        if (bus.clr) begin
            out_d = {N_OUT{1'b0}};
            idx_d = {SEL_W{1'b0}};
        end else if (bus.in_valid) begin
            out_d[target_s] = bus.in_bit;
            strobe_d        = one_hot(target_s);
            if (bus.mode) begin
                idx_d = idx_q + {{(SEL_W-1){1'b0}}, 1'b1};
                if (last_s) begin
                    // Commit includes the bit being written on this same edge.
                    frame_d = out_d;
                    done_d  = 1'b1;
                end else begin
                    frame_d = frame_q;
                end
            end else begin
                idx_d = {SEL_W{1'b0}};
            end
        end else begin
            strobe_d = {N_OUT{1'b0}};
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q    <= {N_OUT{1'b0}};
            strobe_q <= {N_OUT{1'b0}};
            frame_q  <= {N_OUT{1'b0}};
            done_q   <= 1'b0;
            idx_q    <= {SEL_W{1'b0}};
        end else begin
            out_q    <= out_d;
            strobe_q <= strobe_d;
            frame_q  <= frame_d;
            done_q   <= done_d;
            idx_q    <= idx_d;
        end
    end

    assign bus.out        = out_q;
    assign bus.out_strobe = strobe_q;
    assign bus.frame_out  = frame_q;
    assign bus.frame_done = done_q;
    assign bus.scan_idx   = idx_q;

endmodule
